// File: rtl/fft16_unloader.sv
// Captures a 16-lane parallel FFT result into one of two ping-pong banks and
// streams it out one bin per cycle over valid/ready, optionally bit-reversed.
module fft16_unloader #(
  parameter int DW     = 24,
  parameter bit BITREV = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [16*DW-1:0] in_real,
  input  logic [16*DW-1:0] in_imag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_real,
  output logic [DW-1:0]   out_imag,
  output logic [3:0]      out_idx,
  output logic            out_last,
  output logic [7:0]      drop_cnt
);

  logic [DW-1:0] r_bank_re [2][16];
  logic [DW-1:0] r_bank_im [2][16];
  logic [1:0]    r_full;
  logic          r_wsel;
  logic          r_rsel;
  logic [3:0]    r_rcnt;
  logic [7:0]    r_drop;

  logic [DW-1:0] w_in_re [16];
  logic [DW-1:0] w_in_im [16];
  logic [3:0]    w_lane;
  logic          w_cap;
  logic          w_pop;
  logic          w_drop;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_unpack
      assign w_in_re[gi] = in_real[gi*DW +: DW];
      assign w_in_im[gi] = in_imag[gi*DW +: DW];
    end
    // Bit-reversed read lane turns the FFT's scrambled lane order into natural order.
    if (BITREV) begin : g_bitrev
      assign w_lane = {r_rcnt[0], r_rcnt[1], r_rcnt[2], r_rcnt[3]};
    end else begin : g_natural
      assign w_lane = r_rcnt;
    end
  endgenerate

  assign in_ready  = !r_full[0] || !r_full[1];
  assign out_valid = r_full[r_rsel];
  assign out_real  = r_bank_re[r_rsel][w_lane];
  assign out_imag  = r_bank_im[r_rsel][w_lane];
  assign out_idx   = r_rcnt;
  assign out_last  = (r_rcnt == 4'd15);
  assign drop_cnt  = r_drop;

  assign w_cap  = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;
  assign w_drop = in_valid && !in_ready;

  // Bank payload needs no reset: a bank is only read while its full flag is set.
  always_ff @(posedge clk) begin
    if (w_cap) begin
      for (int k = 0; k < 16; k++) begin
        r_bank_re[r_wsel][k] <= w_in_re[k];
        r_bank_im[r_wsel][k] <= w_in_im[k];
      end
    end
  end

  // Capture and last-bin release always target different banks, so both may fire together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full <= 2'b00;
      r_wsel <= 1'b0;
      r_rsel <= 1'b0;
      r_rcnt <= 4'd0;
      r_drop <= 8'd0;
    end else begin
      if (w_cap) begin
        r_full[r_wsel] <= 1'b1;
        r_wsel         <= ~r_wsel;
      end
      if (w_pop) begin
        r_rcnt <= r_rcnt + 4'd1;
        if (r_rcnt == 4'd15) begin
          r_full[r_rsel] <= 1'b0;
          r_rsel         <= ~r_rsel;
        end
      end
      if (w_drop && (r_drop != 8'hFF)) begin
        r_drop <= r_drop + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_fft16_unloader.sv
// Directed + randomized bench for fft16_unloader, checked against a frame-queue model.
module tb_fft16_unloader;
  localparam int DW = 24;

  typedef struct packed {
    logic [16*DW-1:0] re;
    logic [16*DW-1:0] im;
  } frame_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [16*DW-1:0] in_real = '0;
  logic [16*DW-1:0] in_imag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [DW-1:0]    out_real;
  logic [DW-1:0]    out_imag;
  logic [3:0]       out_idx;
  logic             out_last;
  logic [7:0]       drop_cnt;

  logic             b_in_valid = 1'b0;
  logic             b_in_ready;
  logic             b_out_valid;
  logic             b_out_ready = 1'b1;
  logic [DW-1:0]    b_out_real;
  logic [DW-1:0]    b_out_imag;
  logic [3:0]       b_out_idx;
  logic             b_out_last;
  logic [7:0]       b_drop_cnt;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  frame_t mq[$];
  int     mpos  = 0;
  int     mdrop = 0;
  int     beats = 0;

  always #5 clk = ~clk;

  fft16_unloader #(.DW(DW), .BITREV(1'b0)) dut (
    .clk(clk), .rst(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_real(in_real), .in_imag(in_imag), .out_valid(out_valid),
    .out_ready(out_ready), .out_real(out_real), .out_imag(out_imag),
    .out_idx(out_idx), .out_last(out_last), .drop_cnt(drop_cnt)
  );

  fft16_unloader #(.DW(DW), .BITREV(1'b1)) dut_br (
    .clk(clk), .rst(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_real(in_real), .in_imag(in_imag), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_real(b_out_real), .out_imag(b_out_imag),
    .out_idx(b_out_idx), .out_last(b_out_last), .drop_cnt(b_drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else begin
      fail_cnt = fail_cnt + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_frame();
    for (int k = 0; k < 16; k++) begin
      in_real[k*DW +: DW] = DW'($urandom);
      in_imag[k*DW +: DW] = DW'($urandom);
    end
  endtask

  // Compare DUT against the model, then advance one clock and update the model.
  task automatic cycle();
    bit     cap, pop, drp;
    frame_t f;
    if (!rst_n) begin
      mq.delete();
      mpos  = 0;
      mdrop = 0;
    end
    chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    chk("out_idx", 32'(out_idx), 32'(mpos));
    chk("drop_cnt", 32'(drop_cnt), 32'(mdrop));
    if (mq.size() > 0) begin
      chk("out_real", 32'(out_real), 32'(mq[0].re[mpos*DW +: DW]));
      chk("out_imag", 32'(out_imag), 32'(mq[0].im[mpos*DW +: DW]));
      chk("out_last", 32'(out_last), 32'(mpos == 15));
    end
    cap = in_valid && (mq.size() < 2);
    drp = in_valid && !(mq.size() < 2);
    pop = (mq.size() > 0) && out_ready;
    f.re = in_real;
    f.im = in_imag;
    @(posedge clk);
    if (rst_n) begin
      if (pop) begin
        beats++;
        mpos++;
        if (mpos == 16) begin
          mpos = 0;
          void'(mq.pop_front());
          $display("[%0t] frame drained", $time);
        end
      end
      if (cap) begin
        mq.push_back(f);
        $display("[%0t] frame captured (queued=%0d)", $time, mq.size());
      end
      if (drp) begin
        if (mdrop < 255) mdrop++;
        $display("[%0t] frame dropped (drop_cnt model=%0d)", $time, mdrop);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int brseq[16];
    brseq = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    @(negedge clk);
    for (int i = 0; i < 3; i++) cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) cycle();
    chk("idle_ready", 32'(in_ready), 32'd1);
    chk("idle_valid", 32'(out_valid), 32'd0);

    // Single directed frame: FFT of 1,2,3,4 repeated.
    in_real = '0;
    in_imag = '0;
    in_real[0*DW +: DW]  = DW'(40);
    in_real[4*DW +: DW]  = DW'(-8);
    in_imag[4*DW +: DW]  = DW'(8);
    in_real[8*DW +: DW]  = DW'(-8);
    in_real[12*DW +: DW] = DW'(-8);
    in_imag[12*DW +: DW] = DW'(-8);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_bin0", 32'(out_real), 32'd40);
    beats = 0;
    for (int i = 0; i < 20; i++) cycle();
    chk("single_beats", 32'(beats), 32'd16);

    // Bit-reversed instance: lane k = k + j*k.
    for (int k = 0; k < 16; k++) begin
      in_real[k*DW +: DW] = DW'(k);
      in_imag[k*DW +: DW] = DW'(k);
    end
    b_in_valid = 1'b1;
    cycle();
    b_in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("br_valid", 32'(b_out_valid), 32'd1);
      chk("br_idx", 32'(b_out_idx), 32'(i));
      chk("br_real", 32'(b_out_real), 32'(brseq[i]));
      chk("br_imag", 32'(b_out_imag), 32'(brseq[i]));
      $display("[%0t] bitrev beat idx=%0d real=%0d", $time, b_out_idx, b_out_real);
      cycle();
    end
    chk("br_done", 32'(b_out_valid), 32'd0);

    // Random traffic with pseudo-random backpressure.
    for (int i = 0; i < 400; i++) begin
      rand_frame();
      in_valid  = ($urandom_range(0, 15) == 0);
      out_ready = $urandom_range(0, 1) == 1;
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 40 && mq.size() > 0; t++) cycle();
    chk("drained", 32'(out_valid), 32'd0);

    // Reset in the middle of a drain.
    rand_frame();
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    for (int t = 0; t < 40 && !(mq.size() > 0 && mpos == 7); t++) cycle();
    chk("reach_idx7", 32'(out_idx), 32'd7);
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_idx", 32'(out_idx), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
    rand_frame();
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("post_rst_idx", 32'(out_idx), 32'd0);
    for (int i = 0; i < 17; i++) cycle();

    // Ping-pong fill and drop with output stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_frame();
      in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    chk("pp_ready", 32'(in_ready), 32'd0);
    chk("pp_drop", 32'(drop_cnt), 32'd1);
    for (int i = 0; i < 5; i++) cycle();
    out_ready = 1'b1;
    beats = 0;
    for (int i = 0; i < 32; i++) cycle();
    chk("pp_beats", 32'(beats), 32'd32);
    chk("pp_empty", 32'(out_valid), 32'd0);

    // Saturate the drop counter.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 300; i++) begin
      rand_frame();
      cycle();
    end
    in_valid = 1'b0;
    chk("drop_sat", 32'(drop_cnt), 32'd255);
    out_ready = 1'b1;
    for (int i = 0; i < 34; i++) cycle();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fft16_unloader.md
# fft16_unloader

Output-side companion to the 16-point parallel FFT core `fft_1`. It captures one complete 16-bin parallel result (the `y*_real_fin`/`y*_imag_fin` buses) on a strobe and streams it out one bin per cycle over a valid/ready interface. Two capture banks (ping-pong) let the next FFT frame be accepted while the previous one drains. An optional bit-reversal map presents bins in natural frequency order.

## Interface

Parameters:
- `DW`, 24, real/imag sample width (two's complement), matches the FFT output width.
- `BITREV`, 0, 0 = stream output position i from lane i; 1 = stream position i from lane bitrev4(i).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  FFT result on the input buses is valid this cycle.
- `in_ready`  out  1  at least one capture bank is free.
- `in_real`  in  16*DW  lane k = `y{k}_real_fin` at bits [k*DW +: DW].
- `in_imag`  in  16*DW  lane k = `y{k}_imag_fin`, same packing.
- `out_valid`  out  1  a streamed bin is presented.
- `out_ready`  in  1  downstream accepts the bin this cycle.
- `out_real`  out  DW  real part of the current bin.
- `out_imag`  out  DW  imaginary part of the current bin.
- `out_idx`  out  4  output position i (0..15) of the current bin.
- `out_last`  out  1  high with `out_idx` = 15.
- `drop_cnt`  out  8  saturating count of frames offered while `in_ready` = 0.

## Operation

- Storage: banks B0, B1, each 16 x (2*DW) registers, plus flags `full0`, `full1`, write pointer `wsel`, read pointer `rsel`, 4-bit position counter `rcnt`.
- Capture: on `in_valid && in_ready`, all 16 lanes written into bank `wsel`; `full[wsel]` set; `wsel` toggles.
- `in_ready = !full0 || !full1`. It is registered-state only; there is no combinational path from `out_ready`.
- Drop: `in_valid && !in_ready` leaves the banks untouched and increments `drop_cnt`, saturating at 255.
- Drain: `out_valid = full[rsel]`. `out_real`/`out_imag` come from bank `rsel`, lane `rcnt` when `BITREV` = 0, or lane bitrev4(`rcnt`) when `BITREV` = 1. `out_idx = rcnt`.
- On `out_valid && out_ready`: `rcnt` increments. If `rcnt` = 15, `rcnt` wraps to 0, `full[rsel]` clears and `rsel` toggles.
- Data is a pure copy. No scaling, rounding or sign change.
- Simultaneous events:
  - Last bin accepted in the same cycle as a capture into the other bank: both take effect.
  - Both banks full, last bin accepted, and `in_valid` all in the same cycle: `in_ready` was 0, so the frame is dropped and counted. The freed bank is available from the next cycle.
  - `out_ready` low: outputs hold stable, and `rcnt` and the banks are unchanged.
- Reset (asynchronous, any time, including mid-frame):
  - `full0` = `full1` = 0, `wsel` = `rsel` = 0, `rcnt` = 0, `drop_cnt` = 0.
  - Any partial frame is discarded. Bank contents are don't-care.

## Timing

- Reset values: `in_ready` = 1, `out_valid` = 0, `out_idx` = 0, `out_last` = 0, `drop_cnt` = 0. `out_real`/`out_imag` read bank 0 and may be X/0.
- Latency: a frame captured at edge n gives `out_valid` = 1 after edge n when the read bank was empty. Bin 0 is visible in the cycle following capture.
- Throughput: 16 cycles per frame with `out_ready` held high. With frames arriving every 16 cycles, the block sustains full rate with no drops.
- `out_*` change only on a rising edge where the handshake completes, on capture into an empty read bank, or on reset.

## Test plan

- Reset then idle: `rst` low, then high → `in_ready` = 1, `out_valid` = 0, `drop_cnt` = 0 and held for 20 cycles.
- Single frame, `BITREV` = 0, `out_ready` = 1:
  - Stimulus: FFT result of input 1,2,3,4 repeated, i.e. lane0 = 40+0j, lane4 = -8+8j, lane8 = -8+0j, lane12 = -8-8j, all other lanes 0.
  - Response: exactly 16 beats starting the cycle after capture, with matching values at `out_idx` 0/4/8/12, zeros elsewhere, and `out_last` only at idx 15.
- `BITREV` = 1, lanes loaded with lane k = k+j*k:
  - Response: `out_real` sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15, with `out_imag` equal to `out_real`.
- Backpressure: toggle `out_ready` pseudo-randomly during a frame.
  - Response: 16 beats in order, and outputs stay stable while `out_valid && !out_ready`.
- Ping-pong and drop: hold `out_ready` = 0 and offer 3 frames (A, B, C) back to back.
  - Response: A and B captured, `in_ready` = 0 after B, C dropped, `drop_cnt` = 1.
  - Then raise `out_ready`: A streams, then B streams, with no gap between them.
  - Continue offering dropped frames until `drop_cnt` stops at 255.
- Reset mid-drain: assert `rst` at `out_idx` = 7.
  - Response: `out_valid` drops immediately. After release, a new frame streams from idx 0 with no old data.
